// File: rtl/timer_pkg.sv
// timer_pkg: state encodings, BCD limits and preset validation for the countdown timer
package timer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  function automatic logic preset_ok(input logic [3:0] mt, input logic [3:0] mo,
                                     input logic [3:0] st, input logic [3:0] so);
    return (mt <= BCD_NINE) && (mo <= BCD_NINE) && (st <= BCD_FIVE) && (so <= BCD_NINE);
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit that wraps 0 -> MAX and signals borrow
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_NINE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out
);
  logic [3:0] q_q, q_d;

  assign q_d        = load ? ld_val : dec_en ? ((q_q == 4'd0) ? MAX : q_q - 4'd1) : q_q;
  assign borrow_out = dec_en & (q_q == 4'd0);
  assign q          = q_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
endmodule

// File: rtl/timer_countdown_bcd.sv
// timer_countdown_bcd: MM:SS BCD countdown with 1 Hz prescaler and load/start/pause/clear FSM
module timer_countdown_bcd
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] ld_min_tens,
  input  logic [3:0] ld_min_ones,
  input  logic [3:0] ld_sec_tens,
  input  logic [3:0] ld_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state,
  output logic       running,
  output logic       done,
  output logic       done_pulse,
  output logic       load_err
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             done_pulse_q, load_err_q;
  logic             tick, zero, last, ld_valid, ld_cmd, ld_ok, ld_bad, clr_dig, dig_ld;
  logic [3:0]       b;

  assign tick     = (state_q == ST_RUN) && (pre_q == CNT_W'(TICK_DIV - 1));
  assign zero     = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
  assign last     = tick && ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
  assign ld_valid = preset_ok(ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones);
  assign ld_cmd   = load && (state_q != ST_RUN);
  assign ld_ok    = ld_cmd && ld_valid;
  assign ld_bad   = ld_cmd && !ld_valid;
  // a borrow out of the top digit would mean wrapping below 00:00, so force zero instead
  assign clr_dig  = clear | b[3];
  assign dig_ld   = clr_dig | ld_ok;

  bcd_down_digit #(.MAX(BCD_NINE)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .load(dig_ld), .ld_val(clr_dig ? 4'd0 : ld_sec_ones),
    .dec_en(tick), .q(sec_ones), .borrow_out(b[0])
  );
  bcd_down_digit #(.MAX(BCD_FIVE)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .load(dig_ld), .ld_val(clr_dig ? 4'd0 : ld_sec_tens),
    .dec_en(b[0]), .q(sec_tens), .borrow_out(b[1])
  );
  bcd_down_digit #(.MAX(BCD_NINE)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .load(dig_ld), .ld_val(clr_dig ? 4'd0 : ld_min_ones),
    .dec_en(b[1]), .q(min_ones), .borrow_out(b[2])
  );
  bcd_down_digit #(.MAX(BCD_NINE)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .load(dig_ld), .ld_val(clr_dig ? 4'd0 : ld_min_tens),
    .dec_en(b[2]), .q(min_tens), .borrow_out(b[3])
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      done_pulse_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      done_pulse_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
      load_err_q   <= ld_bad && !clear;
    end

  always_comb begin
    state_d = state_q;
    if (clear)                                               state_d = ST_IDLE;
    else if (ld_cmd)                                         state_d = ld_ok ? ST_IDLE : state_q;
    else if (state_q == ST_RUN)                              state_d = last ? ST_DONE : pause ? ST_PAUSE : ST_RUN;
    else if (start && (state_q != ST_DONE) && !zero)         state_d = ST_RUN;
  end

  // IDLE pins the prescaler at 0 so every fresh run starts a full period; PAUSE holds it
  assign pre_d = (clear || ld_ok || state_q == ST_IDLE) ? '0 :
                 (state_q == ST_RUN) ? (tick ? '0 : pre_q + CNT_W'(1)) : pre_q;

  always_comb begin
    state      = state_q;
    running    = state_q == ST_RUN;
    done       = state_q == ST_DONE;
    done_pulse = done_pulse_q;
    load_err   = load_err_q;
  end
endmodule

// File: doc/timer_countdown_bcd.md
Name: timer_countdown_bcd

Overview:
MM:SS countdown timer core that produces the four BCD digits consumed by the per-digit led_7_segment decoders. It divides the system clock down to a 1 Hz tick and runs a load/start/pause/clear state machine. It decrements a cascaded BCD count with borrow and flags expiry. One instance drives one 4-digit display.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count tick (1 Hz at 50 MHz); must be >= 2; bench uses 4.
CNT_W, 26, prescaler width; must satisfy 2**CNT_W >= TICK_DIV.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear to 00:00 / IDLE
load  in  1  load preset from ld_* digits
start  in  1  start or resume counting
pause  in  1  pause counting
ld_min_tens  in  4  preset BCD, 0..9
ld_min_ones  in  4  preset BCD, 0..9
ld_sec_tens  in  4  preset BCD, 0..5
ld_sec_ones  in  4  preset BCD, 0..9
min_tens  out  4  BCD digit to decoder
min_ones  out  4  BCD digit to decoder
sec_tens  out  4  BCD digit to decoder
sec_ones  out  4  BCD digit to decoder
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
running  out  1  high iff state==RUN
done  out  1  high iff state==DONE
done_pulse  out  1  one-cycle pulse on entry to DONE
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset: rst_n low asynchronously forces all digits to 0, state to IDLE, prescaler to 0, and running, done, done_pulse, load_err to 0. Release is synchronous to clk.
- All outputs are registered. A count change appears on the cycle after the tick cycle.
- Prescaler:
  - Counts only in RUN.
  - tick = (prescaler == TICK_DIV-1). On tick the prescaler wraps to 0.
  - Cleared on IDLE->RUN, on clear, and on load.
  - Held, not cleared, across PAUSE.
- Command priority each cycle: clear > load > start > pause.
- clear: any state -> IDLE, digits set to 0.
- load, accepted in IDLE, PAUSE or DONE:
  - Digits take the ld_* values and state goes to IDLE.
  - Rejected if any digit > 9 or ld_sec_tens > 5: digits and state are unchanged and load_err pulses.
  - Ignored in RUN, with no load_err.
- start:
  - IDLE or PAUSE -> RUN if the count is not 00:00.
  - Ignored if the count is 00:00, in RUN, or in DONE.
- pause: RUN -> PAUSE; ignored in other states.
- Decrement on tick in RUN:
  - sec_ones 0 -> 9 with borrow, otherwise -1.
  - sec_tens on borrow: 0 -> 5 with borrow, otherwise -1.
  - min_ones on borrow: 0 -> 9 with borrow, otherwise -1.
  - min_tens on borrow: -1.
  - Maximum preset is 99:59.
- Expiry: if a tick moves the count to 00:00, state -> DONE on the same edge and done_pulse is high for exactly that one cycle. The count never wraps below 00:00.
- Tick and pause in the same RUN cycle: the decrement is applied, then state -> PAUSE.
- Tick reaching 00:00 and pause in the same cycle: DONE wins.
- DONE holds 00:00 until clear or a valid load.

Decomposition:
- Package timer_pkg:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - BCD_NINE=4'd9, BCD_FIVE=4'd5.
  - A function that checks a 4-digit preset for validity.
- Sub-module bcd_down_digit:
  - Parameter MAX (9 or 5).
  - Inputs: clk, rst_n, load, ld_val, dec_en.
  - Outputs: q, borrow_out, where borrow_out = dec_en & (q==0).
  - Instantiated four times in a borrow chain.
- The top level holds the FSM, prescaler and command priority.

Test Plan (TICK_DIV=4):
1. Load 00:03, start -> running=1. Digits read 00:02, 00:01, 00:00 at 4-cycle intervals. done_pulse fires once with the final change, and done stays at 1.
2. Load 10:00, start, one tick -> 09:59, showing borrow through all four digits. Load 00:10, one tick -> 00:09.
3. Load 00:05, start, assert pause two cycles after the first tick -> state=PAUSE, count frozen at 00:04 for 20 cycles. Start -> the next tick arrives exactly 2 cycles after resume (prescaler retained).
4. Load with ld_sec_tens=6 -> load_err pulses for 1 cycle, digits unchanged. Load during RUN -> ignored, no load_err. Start on 00:00 -> stays IDLE.
5. Assert clear, load and start together in RUN -> IDLE, 00:00. Load and start together in IDLE -> load wins, state IDLE.
6. rst_n low mid-RUN, asynchronously between clock edges -> all outputs are 0 and state is IDLE before the next edge. After release, the block stays in IDLE with no tick.
